// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge: FSM state encoding,
// access-size codes and the MIPS kernel-segment boundaries.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [31:0] KSEG0_BASE     = 32'h8000_0000;
  localparam logic [31:0] KSEG1_BASE     = 32'hA000_0000;
  localparam logic [31:0] KSEG2_BASE     = 32'hC000_0000;
  localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;

endpackage

// File: rtl/dmem_addr_map.sv
// Combinational virtual-to-physical address translator for the data bus.
// Defining DMEM_ADDR_MAP_EN folds kseg0/kseg1 onto the low 512 MB; otherwise identity.
module dmem_addr_map #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] vaddr_i,
  output logic [AW-1:0] paddr_o
);
  import dmem_bridge_pkg::*;

`ifdef DMEM_ADDR_MAP_EN
  logic in_kseg01;

  // kseg0 and kseg1 are unmapped windows onto the same physical range.
  assign in_kseg01 = (vaddr_i >= AW'(KSEG0_BASE)) && (vaddr_i < AW'(KSEG2_BASE));
  assign paddr_o   = in_kseg01 ? (vaddr_i & AW'(KSEG_PHYS_MASK)) : vaddr_i;
`else
  assign paddr_o = vaddr_i;
`endif

endmodule

// File: rtl/dmem_bridge.sv
// M-stage data-side bridge: turns a single-cycle load/store into a req/addr_ok/data_ok
// bus transaction, stalling the pipeline until done. Optional DMEM_ADDR_MAP_EN remaps kseg0/1.
module dmem_bridge #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_en,
  input  logic [3:0]    cpu_wen,
  input  logic [1:0]    cpu_size,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_flush,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata
);
  import dmem_bridge_pkg::*;

  state_e        state_q;
  logic          cancel_q;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  logic [AW-1:0] paddr_d;
  logic          issue_d;
  logic          cancel_d;

  dmem_addr_map #(.AW(AW)) u_addr_map (
    .vaddr_i (cpu_addr),
    .paddr_o (paddr_d)
  );

  // Issue is gated by rst so the bus sees no request while reset is held.
  assign issue_d  = rst & (state_q == IDLE) & cpu_en & ~cpu_flush;
  assign cancel_d = cancel_q | cpu_flush;

  // Request fields are live in the issue cycle, then held from the latched copy.
  assign data_req   = issue_d | (state_q == REQ);
  assign data_wr    = issue_d ? |cpu_wen  : wr_q;
  assign data_size  = issue_d ? cpu_size  : size_q;
  assign data_addr  = issue_d ? paddr_d   : addr_q;
  assign data_wdata = issue_d ? cpu_wdata : wdata_q;

  assign cpu_stall = issue_d | (state_q == REQ) | (state_q == WAIT);
  assign cpu_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cancel_q <= 1'b0;
          if (issue_d) begin
            wr_q    <= |cpu_wen;
            size_q  <= cpu_size;
            addr_q  <= paddr_d;
            wdata_q <= cpu_wdata;
            state_q <= data_addr_ok ? WAIT : REQ;
          end
        end
        REQ: begin
          cancel_q <= cancel_d;
          if (data_addr_ok) state_q <= WAIT;
        end
        WAIT: begin
          // A cancelled access still drains the bus but never reaches DONE.
          if (data_data_ok) begin
            cancel_q <= 1'b0;
            if (cancel_d) begin
              state_q <= IDLE;
            end else begin
              if (!wr_q) rdata_q <= data_rdata;
              state_q <= DONE;
            end
          end else begin
            cancel_q <= cancel_d;
          end
        end
        DONE: begin
          cancel_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: cycle-stepped bus responder with a load-data scoreboard.
module tb_dmem_bridge;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_flush;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] last_rdata;

`ifdef DMEM_ADDR_MAP_EN
  localparam logic [31:0] EXP_LD_ADDR = 32'h0000_0010;
`else
  localparam logic [31:0] EXP_LD_ADDR = 32'h8000_0010;
`endif

  dmem_bridge #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_en       (cpu_en),
    .cpu_wen      (cpu_wen),
    .cpu_size     (cpu_size),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_flush    (cpu_flush),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_en = 1'b1; cpu_wen = 4'hF; cpu_size = 2'd2;
    cpu_addr = 32'h8000_0010; cpu_wdata = 32'hA5A5_A5A5; cpu_flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    samp();
    n_checks++; if ({cpu_stall, data_req, data_wr} !== 3'b000) begin n_fail++; $display("FAIL rst_ctrl: got %b want 000", {cpu_stall, data_req, data_wr}); end
    n_checks++; if (data_size !== 2'd0) begin n_fail++; $display("FAIL rst_size: got %0d want 0", data_size); end
    n_checks++; if (data_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", data_addr); end
    n_checks++; if (data_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", data_wdata); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
    cpu_en = 1'b0; cpu_wen = 4'h0; cpu_wdata = 32'h0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_zero_wait();
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_size = 2'd2; cpu_addr = 32'h8000_0010;
    data_addr_ok = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    samp();
    n_checks++; if ({cpu_stall, data_req, data_wr} !== 3'b110) begin n_fail++; $display("FAIL ld_c0_ctrl: got %b want 110", {cpu_stall, data_req, data_wr}); end
    n_checks++; if (data_addr !== EXP_LD_ADDR) begin n_fail++; $display("FAIL ld_c0_addr: got %h want %h", data_addr, EXP_LD_ADDR); end
    n_checks++; if (data_size !== 2'd2) begin n_fail++; $display("FAIL ld_c0_size: got %0d want 2", data_size); end
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b10) begin n_fail++; $display("FAIL ld_c1_ctrl: got %b want 10", {cpu_stall, data_req}); end
    tick();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b00) begin n_fail++; $display("FAIL ld_c2_ctrl: got %b want 00", {cpu_stall, data_req}); end
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    n_checks++; if (cpu_rdata !== exp_v) begin n_fail++; $display("FAIL ld_c2_rdata: got %h want %h", cpu_rdata, exp_v); end
    last_rdata = exp_v;
    tick();
    cpu_en = 1'b0;
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b00) begin n_fail++; $display("FAIL ld_idle_after: got %b want 00", {cpu_stall, data_req}); end
    tick();
  endtask

  task automatic test_store_backpressure();
    cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_size = 2'd0; cpu_addr = 32'h0000_1002;
    cpu_wdata = 32'hABAB_ABAB; data_addr_ok = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) data_addr_ok = 1'b1;
      samp();
      n_checks++; if ({cpu_stall, data_req, data_wr} !== 3'b111) begin n_fail++; $display("FAIL st_req_c%0d: got %b want 111", c, {cpu_stall, data_req, data_wr}); end
      n_checks++; if ({data_size, data_addr, data_wdata} !== {2'd0, 32'h0000_1002, 32'hABAB_ABAB}) begin n_fail++; $display("FAIL st_fields_c%0d: got size %0d addr %h wdata %h want 0 00001002 abababab", c, data_size, data_addr, data_wdata); end
      tick();
      data_addr_ok = 1'b0;
      cpu_addr = 32'hFFFF_FFF0 + 32'(c);
      cpu_wdata = $urandom;
      cpu_size = 2'd2;
    end
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b10) begin n_fail++; $display("FAIL st_wait0: got %b want 10", {cpu_stall, data_req}); end
    tick();
    data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b10) begin n_fail++; $display("FAIL st_wait1: got %b want 10", {cpu_stall, data_req}); end
    tick();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b00) begin n_fail++; $display("FAIL st_done: got %b want 00", {cpu_stall, data_req}); end
    n_checks++; if (cpu_rdata !== last_rdata) begin n_fail++; $display("FAIL st_rdata_kept: got %h want %h", cpu_rdata, last_rdata); end
    tick();
    cpu_en = 1'b0; cpu_wen = 4'h0; cpu_wdata = 32'h0;
    tick();
  endtask

  task automatic test_flush_idle();
    cpu_en = 1'b1; cpu_flush = 1'b1; cpu_wen = 4'h0; cpu_size = 2'd2;
    cpu_addr = 32'h0000_2000; data_addr_ok = 1'b1;
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b00) begin n_fail++; $display("FAIL fli_c0: got %b want 00", {cpu_stall, data_req}); end
    tick();
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b00) begin n_fail++; $display("FAIL fli_c1: got %b want 00", {cpu_stall, data_req}); end
    tick();
    cpu_flush = 1'b0; cpu_en = 1'b0; data_addr_ok = 1'b0;
    tick();
  endtask

  task automatic test_flush_wait();
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_size = 2'd2; cpu_addr = 32'h0000_2000;
    data_addr_ok = 1'b1;
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b11) begin n_fail++; $display("FAIL flw_issue: got %b want 11", {cpu_stall, data_req}); end
    tick();
    data_addr_ok = 1'b0; cpu_flush = 1'b1;
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b10) begin n_fail++; $display("FAIL flw_wait_flush: got %b want 10", {cpu_stall, data_req}); end
    tick();
    cpu_flush = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b10) begin n_fail++; $display("FAIL flw_hold: got %b want 10", {cpu_stall, data_req}); end
    tick();
    // back in IDLE (not DONE): a pending cpu_en must issue immediately
    data_data_ok = 1'b0; data_rdata = 32'h0; cpu_addr = 32'h0000_3000; data_addr_ok = 1'b1;
    exp_q.push_back(32'hCAFE_F00D);
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b11) begin n_fail++; $display("FAIL flw_no_done: got %b want 11", {cpu_stall, data_req}); end
    n_checks++; if (cpu_rdata !== last_rdata) begin n_fail++; $display("FAIL flw_rdata_kept: got %h want %h", cpu_rdata, last_rdata); end
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b10) begin n_fail++; $display("FAIL flw_ld2_wait: got %b want 10", {cpu_stall, data_req}); end
    tick();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    samp();
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    n_checks++; if ({cpu_stall, cpu_rdata} !== {1'b0, exp_v}) begin n_fail++; $display("FAIL flw_ld2_done: got stall %b rdata %h want 0 %h", cpu_stall, cpu_rdata, exp_v); end
    last_rdata = exp_v;
    tick();
    cpu_en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_size = 2'd2; cpu_addr = 32'h0000_0100;
    data_addr_ok = 1'b1;
    exp_q.push_back(32'h1111_1111);
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b11) begin n_fail++; $display("FAIL b2b_a_issue: got %b want 11", {cpu_stall, data_req}); end
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
    tick();
    data_data_ok = 1'b0; data_rdata = 32'h0; cpu_addr = 32'h0000_0104; data_addr_ok = 1'b1;
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b00) begin n_fail++; $display("FAIL b2b_done_noissue: got %b want 00", {cpu_stall, data_req}); end
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    n_checks++; if (cpu_rdata !== exp_v) begin n_fail++; $display("FAIL b2b_a_rdata: got %h want %h", cpu_rdata, exp_v); end
    tick();
    exp_q.push_back(32'h2222_2222);
    samp();
    n_checks++; if ({cpu_stall, data_req, data_addr} !== {2'b11, 32'h0000_0104}) begin n_fail++; $display("FAIL b2b_b_issue: got %b %h want 11 00000104", {cpu_stall, data_req}, data_addr); end
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h2222_2222;
    tick();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    samp();
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    n_checks++; if ({cpu_stall, cpu_rdata} !== {1'b0, exp_v}) begin n_fail++; $display("FAIL b2b_b_done: got stall %b rdata %h want 0 %h", cpu_stall, cpu_rdata, exp_v); end
    tick();
    cpu_en = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_size = 2'd0; cpu_addr = 32'h0000_4000;
    cpu_wdata = 32'h7777_7777; data_addr_ok = 1'b0;
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b11) begin n_fail++; $display("FAIL mrst_issue: got %b want 11", {cpu_stall, data_req}); end
    tick();
    samp();
    n_checks++; if ({cpu_stall, data_req, data_addr} !== {2'b11, 32'h0000_4000}) begin n_fail++; $display("FAIL mrst_req: got %b %h want 11 00004000", {cpu_stall, data_req}, data_addr); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if ({cpu_stall, data_req, data_wr} !== 3'b000) begin n_fail++; $display("FAIL mrst_async_ctrl: got %b want 000", {cpu_stall, data_req, data_wr}); end
    n_checks++; if ({data_addr, data_wdata, cpu_rdata} !== 96'h0) begin n_fail++; $display("FAIL mrst_regs_clear: got %h %h %h want 0 0 0", data_addr, data_wdata, cpu_rdata); end
    tick();
    cpu_en = 1'b0; cpu_wen = 4'h0; cpu_wdata = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    samp();
    n_checks++; if ({cpu_stall, data_req} !== 2'b00) begin n_fail++; $display("FAIL mrst_idle: got %b want 00", {cpu_stall, data_req}); end
    tick();
  endtask

  initial begin
    last_rdata = 32'h0;
    test_reset();
    test_load_zero_wait();
    test_store_backpressure();
    test_flush_idle();
    test_flush_wait();
    test_back_to_back();
    test_mid_reset();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
